// File: rtl/core_boot_irq_ctrl.sv
// ============================================================================
// Module      : core_boot_irq_ctrl
// Description : Core start-up sequencer (delayed fetch enable, aligned boot
//               address, drain on stop) plus fast-interrupt conditioning.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_boot_irq_ctrl #(
    parameter int NumIrqs       = 16,
    parameter int BootAlignBits = 8,
    parameter int StartDelay    = 4,
    parameter int IdxW          = (NumIrqs > 1) ? $clog2(NumIrqs) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               fetch_enable_i,
    input  logic [31:0]        boot_addr_i,
    input  logic               core_busy_i,
    output logic               fetch_enable_o,
    output logic [31:0]        boot_addr_o,
    output logic               running_o,

    input  logic [NumIrqs-1:0] irqs_i,
    input  logic [NumIrqs-1:0] irq_edge_i,
    input  logic [NumIrqs-1:0] irq_en_i,
    input  logic               clr_valid_i,
    input  logic [IdxW-1:0]    clr_idx_i,
    output logic [NumIrqs-1:0] irqs_o,
    output logic [NumIrqs-1:0] irq_pending_o,
    output logic [NumIrqs-1:0] irq_ovf_o
);

    localparam int               CntW      = (StartDelay > 1) ? $clog2(StartDelay) : 1;
    localparam logic [CntW-1:0]  DelayInit = CntW'(StartDelay - 1);
    localparam logic [31:0]      BootMask  = ~((32'd1 << BootAlignBits) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Start-up sequencer
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     boot_q, boot_d;
    logic            fetch_en_q;
    logic            running_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            boot_q     <= '0;
            fetch_en_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            boot_q     <= boot_d;
            fetch_en_q <= (state_d == ST_RUN);
            running_q  <= (state_d == ST_RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        boot_d  = boot_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_enable_i) begin
                    state_d = ST_DELAY;
                    cnt_d   = DelayInit;
                    boot_d  = boot_addr_i & BootMask;
                end
            end
            ST_DELAY: begin
                // A dropped request aborts before the core ever sees fetch enable
                if (!fetch_enable_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            ST_RUN: begin
                if (!fetch_enable_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!core_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fetch_enable_o = fetch_en_q;
    assign running_o      = running_q;
    assign boot_addr_o    = boot_q;

    // ------------------------------------------------------------------
    // Fast-interrupt conditioning
    // ------------------------------------------------------------------
    logic [NumIrqs-1:0] pend_q, pend_d;
    logic [NumIrqs-1:0] ovf_q, ovf_d;
    logic [NumIrqs-1:0] hist_q, hist_d;
    logic [NumIrqs-1:0] mode_q;
    logic [NumIrqs-1:0] mode_chg;
    logic [NumIrqs-1:0] rise;
    logic [NumIrqs-1:0] clr_hit;

    assign mode_chg = irq_edge_i ^ mode_q;
    assign rise     = irqs_i & ~hist_q;
    assign hist_d   = irqs_i & ~mode_chg;

    // Compared at 32 bits so an index beyond the last line never matches
    always_comb begin
        clr_hit = '0;
        for (int i = 0; i < NumIrqs; i++) begin
            clr_hit[i] = clr_valid_i && (32'(clr_idx_i) == 32'(i));
        end
    end

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < NumIrqs; i++) begin
            if (mode_chg[i]) begin
                pend_d[i] = 1'b0;
            end else if (!irq_edge_i[i]) begin
                pend_d[i] = irqs_i[i];
            end else if (rise[i]) begin
                // Set beats a coincident clear; only an unserviced repeat overflows
                pend_d[i] = 1'b1;
                if (pend_q[i] && !clr_hit[i]) begin
                    ovf_d[i] = 1'b1;
                end
            end else if (clr_hit[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
            ovf_q  <= '0;
            hist_q <= '0;
            mode_q <= '0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            hist_q <= hist_d;
            mode_q <= irq_edge_i;
        end
    end

    assign irqs_o        = pend_q & irq_en_i & {NumIrqs{running_q}};
    assign irq_pending_o = pend_q;
    assign irq_ovf_o     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_core_boot_irq_ctrl.sv
// ============================================================================
// Module      : tb_core_boot_irq_ctrl
// Description : Scoreboard bench for core_boot_irq_ctrl: directed start-up and
//               interrupt scenarios followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_boot_irq_ctrl;

    localparam int N     = 16;
    localparam int ALIGN = 8;
    localparam int SD    = 4;
    localparam int IW    = 5;

    localparam int PH_IDLE  = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_DRAIN = 3;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          fetch_enable_i;
    logic [31:0]   boot_addr_i;
    logic          core_busy_i;
    logic          fetch_enable_o;
    logic [31:0]   boot_addr_o;
    logic          running_o;
    logic [N-1:0]  irqs_i;
    logic [N-1:0]  irq_edge_i;
    logic [N-1:0]  irq_en_i;
    logic          clr_valid_i;
    logic [IW-1:0] clr_idx_i;
    logic [N-1:0]  irqs_o;
    logic [N-1:0]  irq_pending_o;
    logic [N-1:0]  irq_ovf_o;

    always #5 clk = ~clk;

    core_boot_irq_ctrl #(
        .NumIrqs      (N),
        .BootAlignBits(ALIGN),
        .StartDelay   (SD),
        .IdxW         (IW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .fetch_enable_i(fetch_enable_i),
        .boot_addr_i   (boot_addr_i),
        .core_busy_i   (core_busy_i),
        .fetch_enable_o(fetch_enable_o),
        .boot_addr_o   (boot_addr_o),
        .running_o     (running_o),
        .irqs_i        (irqs_i),
        .irq_edge_i    (irq_edge_i),
        .irq_en_i      (irq_en_i),
        .clr_valid_i   (clr_valid_i),
        .clr_idx_i     (clr_idx_i),
        .irqs_o        (irqs_o),
        .irq_pending_o (irq_pending_o),
        .irq_ovf_o     (irq_ovf_o)
    );

    typedef struct {
        logic         fe;
        logic         run;
        logic [31:0]  boot;
        logic [N-1:0] pend;
        logic [N-1:0] ovf;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: updates on every clock edge from the inputs it saw
    int           m_phase = PH_IDLE;
    int           m_age   = 0;
    logic [31:0]  m_boot  = '0;
    logic [N-1:0] m_pend  = '0;
    logic [N-1:0] m_ovf   = '0;
    logic [N-1:0] m_hist  = '0;
    logic [N-1:0] m_mode  = '0;

    always @(posedge clk) begin : model
        exp_t e;
        logic edge_seen;
        logic clr_here;
        if (rst_i) begin
            m_phase = PH_IDLE;
            m_age   = 0;
            m_boot  = '0;
            m_pend  = '0;
            m_ovf   = '0;
            m_hist  = '0;
            m_mode  = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                edge_seen = irqs_i[i] && !m_hist[i];
                clr_here  = clr_valid_i && (int'(clr_idx_i) == i);
                if (irq_edge_i[i] != m_mode[i]) begin
                    m_pend[i] = 1'b0;
                    m_hist[i] = 1'b0;
                end else begin
                    if (!irq_edge_i[i]) begin
                        m_pend[i] = irqs_i[i];
                    end else if (edge_seen) begin
                        if (m_pend[i] && !clr_here) m_ovf[i] = 1'b1;
                        m_pend[i] = 1'b1;
                    end else if (clr_here) begin
                        m_pend[i] = 1'b0;
                    end
                    m_hist[i] = irqs_i[i];
                end
                m_mode[i] = irq_edge_i[i];
            end
            // m_age counts cycles spent waiting since the request was accepted
            if (m_phase == PH_IDLE) begin
                if (fetch_enable_i) begin
                    m_phase = PH_WAIT;
                    m_age   = 1;
                    m_boot  = {boot_addr_i[31:ALIGN], {ALIGN{1'b0}}};
                end
            end else if (m_phase == PH_WAIT) begin
                if (!fetch_enable_i) m_phase = PH_IDLE;
                else if (m_age == SD) m_phase = PH_RUN;
                else m_age = m_age + 1;
            end else if (m_phase == PH_RUN) begin
                if (!fetch_enable_i) m_phase = PH_DRAIN;
            end else begin
                if (!core_busy_i) m_phase = PH_IDLE;
            end
        end
        e.fe   = (m_phase == PH_RUN);
        e.run  = (m_phase == PH_RUN);
        e.boot = m_boot;
        e.pend = m_pend;
        e.ovf  = m_ovf;
        sbq.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("fetch_enable_o", 32'(fetch_enable_o), 32'(e.fe));
            chk("running_o", 32'(running_o), 32'(e.run));
            chk("boot_addr_o", boot_addr_o, e.boot);
            chk("irq_pending_o", 32'(irq_pending_o), 32'(e.pend));
            chk("irq_ovf_o", 32'(irq_ovf_o), 32'(e.ovf));
            chk("irqs_o", 32'(irqs_o), 32'(e.pend & irq_en_i & {N{e.run}}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_i          = 1'b1;
        fetch_enable_i = 1'b0;
        boot_addr_i    = '0;
        core_busy_i    = 1'b0;
        irqs_i         = '0;
        irq_edge_i     = '0;
        irq_en_i       = '0;
        clr_valid_i    = 1'b0;
        clr_idx_i      = '0;
        tick();
        tick();
        rst_i = 1'b0;
        chk("reset fetch_enable_o", 32'(fetch_enable_o), 32'd0);
        chk("reset boot_addr_o", boot_addr_o, 32'd0);
        chk("reset irq_pending_o", 32'(irq_pending_o), 32'd0);

        irq_edge_i = 16'h0028;
        irq_en_i   = 16'hFFFE;
        tick();
        tick();

        // Edge on line 5 while idle: pending but not delivered
        irqs_i[5] = 1'b1;
        tick();
        irqs_i[5] = 1'b0;
        tick();
        chk("idle pending5", 32'(irq_pending_o[5]), 32'd1);
        chk("idle irqs_o", 32'(irqs_o), 32'd0);

        fetch_enable_i = 1'b1;
        boot_addr_i    = 32'h1000_01A4;
        tick();
        chk("boot aligned", boot_addr_o, 32'h1000_0100);
        chk("fe early", 32'(fetch_enable_o), 32'd0);
        boot_addr_i = 32'hFFFF_FFFF;
        tick();
        tick();
        tick();
        chk("fe cycle4", 32'(fetch_enable_o), 32'd0);
        tick();
        chk("fe cycle5", 32'(fetch_enable_o), 32'd1);
        chk("running cycle5", 32'(running_o), 32'd1);
        chk("irq5 delivered", 32'(irqs_o[5]), 32'd1);
        chk("boot held", boot_addr_o, 32'h1000_0100);

        irqs_i[3] = 1'b1;
        tick();
        irqs_i[3] = 1'b0;
        chk("pend3", 32'(irq_pending_o[3]), 32'd1);
        chk("irq3 out", 32'(irqs_o[3]), 32'd1);
        tick();

        // Edge and clear together: set wins, no overflow
        irqs_i[3]   = 1'b1;
        clr_valid_i = 1'b1;
        clr_idx_i   = 5'd3;
        tick();
        irqs_i[3]   = 1'b0;
        clr_valid_i = 1'b0;
        chk("edge+clr pend3", 32'(irq_pending_o[3]), 32'd1);
        chk("edge+clr ovf3", 32'(irq_ovf_o[3]), 32'd0);
        tick();

        clr_valid_i = 1'b1;
        clr_idx_i   = 5'd20;
        tick();
        clr_valid_i = 1'b0;
        chk("clr idx20 pend", 32'(irq_pending_o), 32'h0000_0028);
        tick();

        irqs_i[3] = 1'b1;
        tick();
        irqs_i[3] = 1'b0;
        chk("ovf3", 32'(irq_ovf_o[3]), 32'd1);
        tick();

        clr_valid_i = 1'b1;
        clr_idx_i   = 5'd3;
        tick();
        clr_valid_i = 1'b0;
        chk("cleared pend3", 32'(irq_pending_o[3]), 32'd0);
        chk("cleared irq3", 32'(irqs_o[3]), 32'd0);
        chk("ovf3 sticky", 32'(irq_ovf_o[3]), 32'd1);
        tick();

        // Level line 0, initially masked
        irqs_i[0] = 1'b1;
        tick();
        chk("lvl pend0", 32'(irq_pending_o[0]), 32'd1);
        chk("lvl masked", 32'(irqs_o[0]), 32'd0);
        irq_en_i[0] = 1'b1;
        #1;
        chk("lvl enabled", 32'(irqs_o[0]), 32'd1);
        irqs_i[0] = 1'b0;
        tick();
        chk("lvl drop pend0", 32'(irq_pending_o[0]), 32'd0);
        chk("lvl drop irq0", 32'(irqs_o[0]), 32'd0);

        // Drain with busy core and an early re-request
        core_busy_i    = 1'b1;
        fetch_enable_i = 1'b0;
        tick();
        chk("drain fe", 32'(fetch_enable_o), 32'd0);
        chk("drain running", 32'(running_o), 32'd0);
        fetch_enable_i = 1'b1;
        tick();
        tick();
        chk("drain rereq", 32'(fetch_enable_o), 32'd0);
        core_busy_i = 1'b0;
        tick();
        tick();
        chk("idle after drain", 32'(fetch_enable_o), 32'd0);
        tick();
        tick();
        tick();
        tick();
        chk("restart fe", 32'(fetch_enable_o), 32'd1);

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst run fe", 32'(fetch_enable_o), 32'd0);
        chk("rst run irqs", 32'(irqs_o), 32'd0);
        chk("rst run pend", 32'(irq_pending_o), 32'd0);
        chk("rst run boot", boot_addr_o, 32'd0);
        tick();

        for (int c = 0; c < 3000; c++) begin
            rst_i       = ($urandom_range(0, 399) == 0);
            irqs_i      = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 31) == 0) irq_edge_i[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) irq_en_i = N'($urandom);
            clr_valid_i = ($urandom_range(0, 3) == 0);
            clr_idx_i   = IW'($urandom_range(0, 31));
            if ($urandom_range(0, 24) == 0) fetch_enable_i = ~fetch_enable_i;
            core_busy_i = $urandom_range(0, 1) == 1;
            boot_addr_i = $urandom;
            tick();
        end

        rst_i          = 1'b0;
        fetch_enable_i = 1'b0;
        irqs_i         = '0;
        clr_valid_i    = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
